// File: rtl/offchip_mem_arbiter.sv
// Round-robin arbiter granting whole-line read/write transactions from N cache
// masters onto a single off-chip memory channel, with optional timeout.
module offchip_mem_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int LINE_BYTES     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int LW = LINE_BYTES * 8,
  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_MASTERS-1:0]          m_read_en_i,
  input  logic [NUM_MASTERS-1:0]          m_write_en_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*LW-1:0]       m_wdata_i,
  output logic [LW-1:0]                   m_rdata_o,
  output logic [NUM_MASTERS-1:0]          m_ready_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic [NUM_MASTERS-1:0]          m_busy_o,
  output logic                            s_read_en_o,
  output logic                            s_write_en_o,
  output logic [ADDR_WIDTH-1:0]           s_addr_o,
  output logic [LW-1:0]                   s_wdata_o,
  input  logic [LW-1:0]                   s_rdata_i,
  input  logic                            s_ready_i
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t                  state_q;
  logic [GW-1:0]           grant_q, last_q, grant_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LW-1:0]           wdata_q, rdata_q;
  logic                    is_write_q, rd_q, wr_q;
  logic [NUM_MASTERS-1:0]  ready_q, err_q, busy_d, grant_oh;
  logic [CW-1:0]           cnt_q;
  logic [NUM_MASTERS-1:0]  req;
  logic                    any_req, timeout_hit;

  assign req         = m_read_en_i | m_write_en_i;
  assign any_req     = |req;
  assign grant_oh    = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << grant_q;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (int'(cnt_q) == TIMEOUT_CYCLES - 1);

  // Scan masters starting just after the previous winner so everyone gets a turn.
  always_comb begin
    logic found;
    found   = 1'b0;
    grant_d = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      int idx;
      idx = (int'(last_q) + k) % NUM_MASTERS;
      if (!found && req[idx]) begin
        found   = 1'b1;
        grant_d = GW'(idx);
      end
    end
  end

  always_comb begin
    busy_d = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      busy_d[i] = (state_q != IDLE) && (grant_q != GW'(i));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= GW'(NUM_MASTERS - 1);
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      is_write_q <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      ready_q    <= '0;
      err_q      <= '0;
      cnt_q      <= '0;
    end else begin
      ready_q <= '0;
      err_q   <= '0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            // A simultaneous read stays pending; the write is served first.
            grant_q    <= grant_d;
            last_q     <= grant_d;
            addr_q     <= m_addr_i[grant_d*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q    <= m_wdata_i[grant_d*LW +: LW];
            is_write_q <= m_write_en_i[grant_d];
            rd_q       <= !m_write_en_i[grant_d];
            wr_q       <= m_write_en_i[grant_d];
            cnt_q      <= '0;
            state_q    <= XFER;
          end
        end
        XFER: begin
          if (s_ready_i) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ready_q <= grant_oh;
            state_q <= RESP;
            if (!is_write_q) rdata_q <= s_rdata_i;
          end else if (timeout_hit) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= grant_oh;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_rdata_o    = rdata_q;
  assign m_ready_o    = ready_q;
  assign m_err_o      = err_q;
  assign m_busy_o     = busy_d;
  assign s_read_en_o  = rd_q;
  assign s_write_en_o = wr_q;
  assign s_addr_o     = addr_q;
  assign s_wdata_o    = wdata_q;

endmodule

// File: tb/tb_offchip_mem_arbiter.sv
// Directed bench for the off-chip arbiter: a 2-master instance with a 16-cycle
// timeout and a 4-master instance for wider round-robin.
module tb_offchip_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [1:0]   mReadEn, mWriteEn, mReady, mErr, mBusy;
  logic [63:0]  mAddr;
  logic [511:0] mWdata;
  logic [255:0] mRdata, sWdata, sRdata;
  logic         sReadEn, sWriteEn, sReady;
  logic [31:0]  sAddr;

  logic [3:0]    qReadEn, qWriteEn, qReady, qErr, qBusy;
  logic [127:0]  qAddr;
  logic [1023:0] qWdata;
  logic [255:0]  qRdata, qsWdata, qsRdata;
  logic          qsReadEn, qsWriteEn, qsReady;
  logic [31:0]   qsAddr;

  int strobeDrops;
  int g;

  always #5 clk = ~clk;

  offchip_mem_arbiter #(.NUM_MASTERS(2), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_read_en_i(mReadEn), .m_write_en_i(mWriteEn),
    .m_addr_i(mAddr), .m_wdata_i(mWdata),
    .m_rdata_o(mRdata), .m_ready_o(mReady), .m_err_o(mErr), .m_busy_o(mBusy),
    .s_read_en_o(sReadEn), .s_write_en_o(sWriteEn),
    .s_addr_o(sAddr), .s_wdata_o(sWdata),
    .s_rdata_i(sRdata), .s_ready_i(sReady)
  );

  offchip_mem_arbiter #(.NUM_MASTERS(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .m_read_en_i(qReadEn), .m_write_en_i(qWriteEn),
    .m_addr_i(qAddr), .m_wdata_i(qWdata),
    .m_rdata_o(qRdata), .m_ready_o(qReady), .m_err_o(qErr), .m_busy_o(qBusy),
    .s_read_en_o(qsReadEn), .s_write_en_o(qsWriteEn),
    .s_addr_o(qsAddr), .s_wdata_o(qsWdata),
    .s_rdata_i(qsRdata), .s_ready_i(qsReady)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] rd, input logic [1:0] wr);
    mReadEn  = rd;
    mWriteEn = wr;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(2'b00, 2'b00);
    sReady  = 1'b0;
    qReadEn = '0;
    qsReady = 1'b0;
    tick();
    tick();
    checkOutput("rst_strobes", {sReadEn, sWriteEn, qsReadEn, qsWriteEn}, 0);
    checkOutput("rst_pulses", {mReady, mErr, mBusy, qReady, qErr, qBusy}, 0);
    checkOutput("rst_rdata", mRdata, 0);
    rst = 1'b0;
  endtask

  initial begin
    mReadEn  = '0;
    mWriteEn = '0;
    mAddr    = '0;
    mWdata   = '0;
    sRdata   = '0;
    sReady   = 1'b0;
    qReadEn  = '0;
    qWriteEn = '0;
    qAddr    = '0;
    qWdata   = '0;
    qsRdata  = '0;
    qsReady  = 1'b0;

    // Single read with a 4-cycle slave.
    doReset();
    mAddr[31:0] = 32'h8000_0040;
    applyStimulus(2'b01, 2'b00);
    checkOutput("t1_c0_idle", sReadEn, 0);
    tick();
    checkOutput("t1_c1_strobe", {sReadEn, sWriteEn}, 2'b10);
    checkOutput("t1_c1_addr", sAddr, 32'h8000_0040);
    checkOutput("t1_c1_busy", mBusy, 2'b10);
    tick();
    tick();
    tick();
    checkOutput("t1_c4_strobe", sReadEn, 1);
    sReady = 1'b1;
    sRdata = {32{8'hA5}};
    tick();
    sReady = 1'b0;
    applyStimulus(2'b00, 2'b00);
    checkOutput("t1_c5_strobe", sReadEn, 0);
    checkOutput("t1_c5_ready", {mReady, mErr}, 4'b0100);
    checkOutput("t1_c5_rdata", mRdata, {32{8'hA5}});
    checkOutput("t1_c5_busy", mBusy, 2'b10);
    tick();
    checkOutput("t1_c6_idle", {mReady, mBusy, sReadEn}, 0);
    sReady = 1'b1;
    tick();
    sReady = 1'b0;
    tick();
    checkOutput("t1_stray_ready", {mReady, mErr, sReadEn}, 0);

    // Two masters reading continuously with a 1-cycle slave.
    doReset();
    mAddr = {32'h0000_0200, 32'h0000_0100};
    applyStimulus(2'b11, 2'b00);
    for (int t = 0; t < 4; t++) begin
      g = t % 2;
      tick();
      checkOutput("t2_strobe", sReadEn, 1);
      checkOutput("t2_addr", sAddr, (g == 0) ? 32'h100 : 32'h200);
      checkOutput("t2_busy", mBusy, (g == 0) ? 2'b10 : 2'b01);
      sReady = 1'b1;
      tick();
      sReady = 1'b0;
      checkOutput("t2_ready", mReady, (g == 0) ? 2'b01 : 2'b10);
      tick();
      checkOutput("t2_idle", {mReady, sReadEn}, 0);
    end
    applyStimulus(2'b00, 2'b00);

    // Write and read together from master 1: write first.
    doReset();
    mAddr[63:32]    = 32'h0000_0300;
    mWdata[511:256] = {8{32'h1234_5678}};
    sRdata          = {32{8'h5A}};
    applyStimulus(2'b10, 2'b10);
    tick();
    checkOutput("t3_wr_strobe", {sReadEn, sWriteEn}, 2'b01);
    checkOutput("t3_wdata", sWdata, {8{32'h1234_5678}});
    checkOutput("t3_addr", sAddr, 32'h300);
    sReady = 1'b1;
    tick();
    sReady = 1'b0;
    checkOutput("t3_wr_ready", mReady, 2'b10);
    checkOutput("t3_wr_rdata_hold", mRdata, 0);
    applyStimulus(2'b10, 2'b00);
    tick();
    tick();
    checkOutput("t3_rd_strobe", {sReadEn, sWriteEn}, 2'b10);
    sReady = 1'b1;
    tick();
    sReady = 1'b0;
    checkOutput("t3_rd_ready", mReady, 2'b10);
    checkOutput("t3_rd_rdata", mRdata, {32{8'h5A}});
    applyStimulus(2'b00, 2'b00);
    tick();

    // Timeout after 16 XFER cycles, then a normal transaction.
    doReset();
    mAddr[31:0] = 32'h0000_0440;
    applyStimulus(2'b01, 2'b00);
    tick();
    strobeDrops = 0;
    for (int c = 2; c <= 16; c++) begin
      tick();
      if (sReadEn !== 1'b1) strobeDrops++;
    end
    checkOutput("t4_hold", strobeDrops, 0);
    checkOutput("t4_c16_err", {mReady, mErr}, 0);
    tick();
    checkOutput("t4_c17_strobe", sReadEn, 0);
    checkOutput("t4_c17_err", {mReady, mErr}, 4'b0001);
    tick();
    checkOutput("t4_c18_clear", {mReady, mErr}, 0);
    tick();
    checkOutput("t4_retry_strobe", sReadEn, 1);
    sReady = 1'b1;
    tick();
    sReady = 1'b0;
    checkOutput("t4_retry_ready", {mReady, mErr}, 4'b0100);
    applyStimulus(2'b00, 2'b00);
    tick();

    // s_ready in the same cycle the limit is reached wins.
    doReset();
    applyStimulus(2'b01, 2'b00);
    for (int c = 1; c <= 16; c++) tick();
    sReady = 1'b1;
    tick();
    sReady = 1'b0;
    checkOutput("t4_edge_ready", {mReady, mErr}, 4'b0100);
    applyStimulus(2'b00, 2'b00);
    tick();

    // Reset in the middle of a read.
    doReset();
    mAddr[31:0] = 32'h0000_0880;
    applyStimulus(2'b01, 2'b00);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("t5_async_drop", {sReadEn, sWriteEn, mBusy}, 0);
    tick();
    tick();
    checkOutput("t5_no_pulse", {mReady, mErr}, 0);
    rst = 1'b0;
    tick();
    checkOutput("t5_regrant", {sReadEn, mBusy, mReady}, 5'b1_10_00);
    checkOutput("t5_addr", sAddr, 32'h880);
    sReady = 1'b1;
    tick();
    sReady = 1'b0;
    checkOutput("t5_ready", mReady, 2'b01);
    applyStimulus(2'b00, 2'b00);
    tick();

    // Four masters, 1 and 3 requesting.
    doReset();
    qAddr   = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    qReadEn = 4'b1010;
    for (int t = 0; t < 4; t++) begin
      g = (t % 2 == 0) ? 1 : 3;
      tick();
      checkOutput("t6_strobe", qsReadEn, 1);
      checkOutput("t6_addr", qsAddr, (g == 1) ? 32'h2000 : 32'h4000);
      checkOutput("t6_busy", qBusy, (g == 1) ? 4'b1101 : 4'b0111);
      qsReady = 1'b1;
      tick();
      qsReady = 1'b0;
      checkOutput("t6_ready", qReady, (g == 1) ? 4'b0010 : 4'b1000);
      tick();
    end
    qReadEn = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/offchip_mem_arbiter.md
Name: offchip_mem_arbiter

Overview:
- Parametrised N-master arbiter for the single off-chip memory line channel shared by the instruction cache, data cache and future DMA/cache masters.
- Replaces direct wiring of several cache controllers onto one off-chip port.
- Grants one whole-line read or write transaction at a time, round-robin, with a per-transaction timeout and error reporting.
- Sits in the system bus between the cache controllers and the off-chip memory model/controller.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (>=2); GW = clog2(NUM_MASTERS).
- LINE_BYTES, 32, cache line size in bytes; LW = LINE_BYTES*8.
- ADDR_WIDTH, 32, line address width.
- TIMEOUT_CYCLES, 0, maximum cycles waiting for s_ready; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- m_read_en  in  NUM_MASTERS  per-master line read request, level
- m_write_en  in  NUM_MASTERS  per-master line write request, level
- m_addr  in  NUM_MASTERS*ADDR_WIDTH  flattened; master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_wdata  in  NUM_MASTERS*LW  flattened write line data
- m_rdata  out  LW  read line, shared by all masters, valid when m_ready[i]
- m_ready  out  NUM_MASTERS  one-cycle completion pulse to the granted master
- m_err  out  NUM_MASTERS  one-cycle timeout pulse to the granted master
- m_busy  out  NUM_MASTERS  bit i high: channel held by a master other than i
- s_read_en  out  1  off-chip read strobe, held until s_ready
- s_write_en  out  1  off-chip write strobe, held until s_ready
- s_addr  out  ADDR_WIDTH  latched transaction address
- s_wdata  out  LW  latched write line
- s_rdata  in  LW  off-chip read line, valid with s_ready
- s_ready  in  1  off-chip completion, one cycle

Behaviour:
- Clocking and reset: single clock domain.
  - rst asynchronously clears every register.
  - All outputs are 0 during reset; state=IDLE; last_grant=NUM_MASTERS-1, so master 0 wins first.
- State machine: IDLE -> XFER -> RESP -> IDLE.
- IDLE: req[i] = m_read_en[i] | m_write_en[i].
  - If any req is set, grant the first requester scanning last_grant+1, last_grant+2, ... modulo NUM_MASTERS.
  - Latch grant, m_addr and m_wdata of the granted master; set is_write = m_write_en[grant].
  - If a master asserts both read and write, the write is served; its read stays pending for a later arbitration.
  - last_grant <= grant; go to XFER.
  - No request: stay in IDLE.
- XFER: s_read_en = !is_write, s_write_en = is_write; s_addr/s_wdata come from the latch.
  - Outputs are registered: the strobe rises the cycle after the grant.
  - The strobe is held until s_ready.
  - On s_ready, latch s_rdata into m_rdata (reads only; m_rdata holds its last value otherwise), drop the strobe and go to RESP.
  - Timeout (TIMEOUT_CYCLES != 0): a counter starts at 0 on entry to XFER and increments every XFER cycle.
  - On reaching TIMEOUT_CYCLES without s_ready, drop the strobe, set err_flag and go to RESP.
  - If s_ready arrives in the same cycle the counter reaches the limit, s_ready wins; it is not an error.
- RESP: pulse m_ready[grant] (or m_err[grant] if err_flag) for exactly one cycle.
  - Clear err_flag; return to IDLE.
  - m_ready and m_err are never both high.
- Latency: request seen at cycle 0 -> strobe high at cycle 1 -> s_ready at cycle k -> m_ready at k+1 -> IDLE at k+2.
  - The next grant is taken at k+2; the next strobe appears at k+3.
- Master contract: a master keeps its request, addr and wdata stable until its m_ready/m_err.
  - The arbiter samples them only in IDLE, so later changes do not affect an in-flight transaction.
  - A request dropped before grant is simply not served.
- m_busy[i] = (state != IDLE) && (grant != i).
- s_ready while not in XFER is ignored.
- Reset mid-transaction: strobes drop immediately and asynchronously; no m_ready or m_err pulse is emitted; arbitration restarts from master 0.

Test Plan:
1. Single read: m0 reads 0x8000_0040; slave asserts s_ready at cycle 4 with s_rdata=0xA5 repeated -> s_read_en high cycles 1-4, s_addr=0x8000_0040; m_ready[0] pulses at cycle 5 with m_rdata=0xA5 repeated; m_ready[1]=0; m_busy[1]=1 during cycles 1-5.
2. Contention: m0 and m1 request reads continuously, slave ready in 1 cycle -> grant order 0,1,0,1; each master gets exactly one m_ready per turn.
3. Write priority: m1 asserts write (wdata=0x1234...) and read together -> first transaction has s_write_en=1 and s_wdata latched; after m_ready[1] the read is served as a separate transaction.
4. Timeout: TIMEOUT_CYCLES=16, slave never ready -> strobe falls after 16 XFER cycles; m_err[0] pulses once, m_ready[0] stays 0; the next request is served normally.
5. Reset mid-XFER: assert rst during cycle 2 of a read -> s_read_en and all outputs 0 immediately; after release, the still-pending m0 request is granted with no spurious m_ready.
6. NUM_MASTERS=4: masters 1 and 3 request after reset -> order 1,3,1,3; m_busy shows 1 for the three non-granted masters.
